block_packet_decoder: RTL and testbench

Receive-side deframer for the server-to-FPGA world stream. Consumes the UART receiver's byte strobes and parses fixed 6-byte block-update packets into one (x, y, z, block type) write per packet for the L3 cache write port. Validates framing, coordinate range and an XOR checksum, and counts good and bad packets. This block pairs with the joystick transmit path: the server answers control bytes with these packets.

---
 rtl/block_pkt_pkg.sv | 37 +++
 rtl/sat_counter.sv | 33 +++
 rtl/block_packet_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_block_packet_decoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkt_pkg.sv
// Shared definitions for the block-update packet deframer.
// Contents:
//   SYNC_BYTE     - first byte of every packet.
//   state_e       - deframer FSM states.
//   block_write_t - raw captured packet fields {x, y, z, blk_type}, one byte each.
// Build option: BLOCK_PKT_CHECKSUM_EN adds the StGetCsum state (6-byte packets).
package block_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef BLOCK_PKT_CHECKSUM_EN
  typedef enum logic [2:0] {
    StHunt,
    StGetX,
    StGetY,
    StGetZ,
    StGetType,
    StGetCsum
  } state_e;
`else
  typedef enum logic [2:0] {
    StHunt,
    StGetX,
    StGetY,
    StGetZ,
    StGetType
  } state_e;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic [7:0] blk_type;
  } block_write_t;

endpackage

// File: rtl/sat_counter.sv
// 16-bit incrementer that sticks at 16'hFFFF instead of wrapping.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (clears the count)
//   inc_i   - add one this cycle
//   count_o - current count
module sat_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/block_packet_decoder.sv
// Receive-side deframer: parses SYNC, X, Y, Z, TYPE[, CSUM] byte packets from the UART
// receiver into single (x, y, z, type) writes held in a one-entry valid/ready slot.
// Rejects packets on coordinate/type range, checksum or slot overrun, and abandons a
// packet after TIMEOUT_CYCLES idle cycles. Good and bad packets are counted.
// Build option: define BLOCK_PKT_CHECKSUM_EN for the 6-byte format with XOR checksum;
// otherwise packets are 5 bytes and complete on the TYPE byte.
// Ports:
//   clk_in, rst_in (async, active-low)
//   byte_in, byte_valid_in          - received byte strobe
//   wr_valid_out, wr_ready_in       - output write handshake
//   x_out, y_out, z_out, block_out  - decoded write
//   busy_out                        - registered, high while mid-packet
//   pkt_count_out, err_count_out    - saturating accepted/rejected counts
module block_packet_decoder
  import block_pkt_pkg::*;
#(
  parameter int unsigned LENGTH         = 64,
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned HEIGHT         = 16,
  parameter int unsigned BLOCK_BITS     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 21700
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid_in,
  output logic                      wr_valid_out,
  input  logic                      wr_ready_in,
  output logic [$clog2(LENGTH)-1:0] x_out,
  output logic [$clog2(WIDTH)-1:0]  y_out,
  output logic [$clog2(HEIGHT)-1:0] z_out,
  output logic [BLOCK_BITS-1:0]     block_out,
  output logic                      busy_out,
  output logic [15:0]               pkt_count_out,
  output logic [15:0]               err_count_out
);

  localparam int unsigned XW    = $clog2(LENGTH);
  localparam int unsigned YW    = $clog2(WIDTH);
  localparam int unsigned ZW    = $clog2(HEIGHT);
  localparam int unsigned IdleW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef BLOCK_PKT_CHECKSUM_EN
  localparam state_e LastState = StGetCsum;
`else
  localparam state_e LastState = StGetType;
`endif

  state_e           state_q, state_d;
  logic [7:0]       x_raw_q, x_raw_d;
  logic [7:0]       y_raw_q, y_raw_d;
  logic [7:0]       z_raw_q, z_raw_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             wr_valid_q, wr_valid_d;
  logic             busy_q;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [ZW-1:0]    z_q, z_d;
  logic [BLOCK_BITS-1:0] blk_q, blk_d;

  block_write_t pkt;
  logic         complete, range_ok, csum_ok, slot_free, accept;
  logic         pkt_inc, err_inc;

`ifdef BLOCK_PKT_CHECKSUM_EN
  logic [7:0] type_raw_q, type_raw_d;
  logic [7:0] csum_q, csum_d;

  // Running XOR over X..TYPE; cleared when SYNC is taken.
  always_comb begin
    type_raw_d = type_raw_q;
    csum_d     = csum_q;
    if (byte_valid_in) begin
      unique case (state_q)
        StHunt:                 csum_d = 8'h00;
        StGetX, StGetY, StGetZ: csum_d = csum_q ^ byte_in;
        StGetType: begin
          type_raw_d = byte_in;
          csum_d     = csum_q ^ byte_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      type_raw_q <= 8'h00;
      csum_q     <= 8'h00;
    end else begin
      type_raw_q <= type_raw_d;
      csum_q     <= csum_d;
    end
  end
`endif

  // Completion checks, evaluated against the byte arriving on the final state.
  always_comb begin
    pkt.x = x_raw_q;
    pkt.y = y_raw_q;
    pkt.z = z_raw_q;
`ifdef BLOCK_PKT_CHECKSUM_EN
    pkt.blk_type = type_raw_q;
    csum_ok      = (csum_q == byte_in);
`else
    pkt.blk_type = byte_in;
    csum_ok      = 1'b1;
`endif
    range_ok  = (32'(pkt.x) < LENGTH) && (32'(pkt.y) < WIDTH) && (32'(pkt.z) < HEIGHT) &&
                ((32'(pkt.blk_type) >> BLOCK_BITS) == 32'd0);
    // Slot may be refilled in the same cycle it is drained.
    slot_free = !wr_valid_q || wr_ready_in;
    complete  = byte_valid_in && (state_q == LastState);
    accept    = complete && range_ok && csum_ok && slot_free;
  end

  always_comb begin
    state_d    = state_q;
    x_raw_d    = x_raw_q;
    y_raw_d    = y_raw_q;
    z_raw_d    = z_raw_q;
    idle_d     = idle_q;
    wr_valid_d = wr_valid_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    blk_d      = blk_q;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;

    if (wr_valid_q && wr_ready_in) begin
      wr_valid_d = 1'b0;
    end

    if (byte_valid_in) begin
      // A byte in the expiry cycle takes priority over the timeout.
      idle_d = '0;
      unique case (state_q)
        StHunt: begin
          if (byte_in == SYNC_BYTE) state_d = StGetX;
        end
        StGetX: begin
          x_raw_d = byte_in;
          state_d = StGetY;
        end
        StGetY: begin
          y_raw_d = byte_in;
          state_d = StGetZ;
        end
        StGetZ: begin
          z_raw_d = byte_in;
          state_d = StGetType;
        end
`ifdef BLOCK_PKT_CHECKSUM_EN
        StGetType: state_d = StGetCsum;
        StGetCsum: state_d = StHunt;
`else
        StGetType: state_d = StHunt;
`endif
        default:   state_d = StHunt;
      endcase

      if (complete) begin
        if (accept) begin
          wr_valid_d = 1'b1;
          x_d        = pkt.x[XW-1:0];
          y_d        = pkt.y[YW-1:0];
          z_d        = pkt.z[ZW-1:0];
          blk_d      = pkt.blk_type[BLOCK_BITS-1:0];
          pkt_inc    = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
      end
    end else if (state_q != StHunt) begin
      if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
        state_d = StHunt;
        idle_d  = '0;
        err_inc = 1'b1;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StHunt;
      x_raw_q    <= 8'h00;
      y_raw_q    <= 8'h00;
      z_raw_q    <= 8'h00;
      idle_q     <= '0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      blk_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_raw_q    <= x_raw_d;
      y_raw_q    <= y_raw_d;
      z_raw_q    <= z_raw_d;
      idle_q     <= idle_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= (state_d != StHunt);
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      blk_q      <= blk_d;
    end
  end

  sat_counter u_pkt_count (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .inc_i  (pkt_inc),
    .count_o(pkt_count_out)
  );

  sat_counter u_err_count (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .inc_i  (err_inc),
    .count_o(err_count_out)
  );

  assign wr_valid_out = wr_valid_q;
  assign busy_out     = busy_q;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign z_out        = z_q;
  assign block_out    = blk_q;

endmodule

// File: tb/tb_block_packet_decoder.sv
// Self-checking bench for block_packet_decoder: table of packets, hand-written corner
// sequences (overrun, timeout boundary, junk + range, reset mid-packet) and random
// traffic, all compared every cycle against a packet-level reference model.
module tb_block_packet_decoder;

  localparam int unsigned LENGTH     = 64;
  localparam int unsigned WIDTH      = 64;
  localparam int unsigned HEIGHT     = 16;
  localparam int unsigned BLOCK_BITS = 5;
  localparam int unsigned TIMEOUT    = 21700;

`ifdef BLOCK_PKT_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif
  // Data bytes after SYNC.
  localparam int DataBytes = CsumEn ? 5 : 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        wr_ready = 1'b0;
  logic        wr_valid;
  logic        busy;
  logic [5:0]  x_out, y_out;
  logic [3:0]  z_out;
  logic [4:0]  block_out;
  logic [15:0] pkt_cnt, err_cnt;

  block_packet_decoder #(
    .LENGTH        (LENGTH),
    .WIDTH         (WIDTH),
    .HEIGHT        (HEIGHT),
    .BLOCK_BITS    (BLOCK_BITS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .byte_in      (byte_in),
    .byte_valid_in(byte_valid),
    .wr_valid_out (wr_valid),
    .wr_ready_in  (wr_ready),
    .x_out        (x_out),
    .y_out        (y_out),
    .z_out        (z_out),
    .block_out    (block_out),
    .busy_out     (busy),
    .pkt_count_out(pkt_cnt),
    .err_count_out(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: position in packet, collected bytes, idle cycles, slot.
  int         m_pos;
  logic [7:0] m_buf[5];
  int         m_idle;
  bit         m_valid;
  int         m_x, m_y, m_z, m_t;
  int         m_pkt, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0; m_idle = 0; m_valid = 1'b0;
    m_x = 0; m_y = 0; m_z = 0; m_t = 0;
    m_pkt = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit bv, logic [7:0] b, bit rdy);
    bit old_valid = m_valid;
    bit ok;
    if (old_valid && rdy) m_valid = 1'b0;
    if (bv) begin
      m_idle = 0;
      if (m_pos == 0) begin
        if (b == 8'hA5) m_pos = 1;
      end else if (m_pos < DataBytes) begin
        m_buf[m_pos-1] = b;
        m_pos++;
      end else begin
        m_buf[m_pos-1] = b;
        ok = (int'(m_buf[0]) < LENGTH) && (int'(m_buf[1]) < WIDTH) &&
             (int'(m_buf[2]) < HEIGHT) && (int'(m_buf[3]) < (1 << BLOCK_BITS)) &&
             (!CsumEn || (m_buf[4] == (m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3]))) &&
             (!old_valid || rdy);
        if (ok) begin
          m_valid = 1'b1;
          m_x = int'(m_buf[0]); m_y = int'(m_buf[1]);
          m_z = int'(m_buf[2]); m_t = int'(m_buf[3]);
          if (m_pkt < 65535) m_pkt++;
        end else begin
          if (m_err < 65535) m_err++;
        end
        m_pos = 0;
      end
    end else if (m_pos != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_pos = 0;
        m_idle = 0;
        if (m_err < 65535) m_err++;
      end
    end
  endfunction

  task automatic check_model();
    chk("m_wr_valid", wr_valid, m_valid);
    chk("m_busy", busy, m_pos != 0);
    chk("m_x", x_out, m_x);
    chk("m_y", y_out, m_y);
    chk("m_z", z_out, m_z);
    chk("m_block", block_out, m_t);
    chk("m_pkt_count", pkt_cnt, m_pkt);
    chk("m_err_count", err_cnt, m_err);
  endtask

  task automatic step(input bit bv, input logic [7:0] b, input bit rdy);
    byte_valid = bv;
    byte_in    = b;
    wr_ready   = rdy;
    @(posedge clk);
    model_step(bv, b, rdy);
    #1;
    byte_valid = 1'b0;
    check_model();
  endtask

  task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                          input logic [7:0] t, input logic [7:0] cx, input bit rdy);
    step(1'b1, 8'hA5, rdy);
    step(1'b1, x, rdy);
    step(1'b1, y, rdy);
    step(1'b1, z, rdy);
    step(1'b1, t, rdy);
    if (CsumEn) step(1'b1, x ^ y ^ z ^ t ^ cx, rdy);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_block", block_out, 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_err", err_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic [7:0] t;
    logic [7:0] cx;   // XOR applied to the correct checksum; nonzero corrupts it
    bit         rng;  // fields are in range
  } vec_t;

  initial begin
    vec_t tbl[10];
    int   exp_pkt, exp_err;
    bit   acc;

    tbl[0] = '{8'd3,  8'd5,  8'd2,  8'd7,  8'h00, 1'b1};
    tbl[1] = '{8'd3,  8'd5,  8'd2,  8'd7,  8'h07, 1'b1};  // CSUM 04 instead of 03
    tbl[2] = '{8'd3,  8'd5,  8'd2,  8'd7,  8'h00, 1'b1};
    tbl[3] = '{8'd63, 8'd63, 8'd15, 8'd31, 8'h00, 1'b1};
    tbl[4] = '{8'd64, 8'd0,  8'd0,  8'd0,  8'h00, 1'b0};
    tbl[5] = '{8'd0,  8'd64, 8'd0,  8'd0,  8'h00, 1'b0};
    tbl[6] = '{8'd0,  8'd0,  8'd16, 8'd0,  8'h00, 1'b0};
    tbl[7] = '{8'd0,  8'd0,  8'd0,  8'd32, 8'h00, 1'b0};
    tbl[8] = '{8'hA5, 8'd1,  8'd1,  8'd1,  8'h00, 1'b0};
    tbl[9] = '{8'd0,  8'd0,  8'd0,  8'd0,  8'h00, 1'b1};

    model_reset();
    apply_reset();

    // Table: ready held high, each write pulses for exactly one cycle.
    exp_pkt = 0;
    exp_err = 0;
    for (int i = 0; i < 10; i++) begin
      acc = tbl[i].rng && (!CsumEn || (tbl[i].cx == 8'h00));
      send_pkt(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].t, tbl[i].cx, 1'b1);
      chk("tbl_valid", wr_valid, acc);
      if (acc) begin
        chk("tbl_x", x_out, tbl[i].x);
        chk("tbl_y", y_out, tbl[i].y);
        chk("tbl_z", z_out, tbl[i].z);
        chk("tbl_block", block_out, tbl[i].t);
        exp_pkt++;
      end else begin
        exp_err++;
      end
      chk("tbl_pkt", pkt_cnt, exp_pkt);
      chk("tbl_err", err_cnt, exp_err);
      step(1'b0, 8'h00, 1'b1);
      chk("tbl_pulse", wr_valid, 0);
    end

    // Overrun: slot held by first packet while ready is low.
    send_pkt(8'd10, 8'd11, 8'd12, 8'd13, 8'h00, 1'b0);
    chk("ovr_first_valid", wr_valid, 1);
    exp_pkt++;
    send_pkt(8'd20, 8'd21, 8'd3, 8'd4, 8'h00, 1'b0);
    exp_err++;
    chk("ovr_err", err_cnt, exp_err);
    chk("ovr_x_held", x_out, 10);
    chk("ovr_valid_held", wr_valid, 1);
    chk("ovr_pkt", pkt_cnt, exp_pkt);
    step(1'b0, 8'h00, 1'b1);
    chk("ovr_drain", wr_valid, 0);

    // Timeout fires on idle cycle TIMEOUT.
    step(1'b1, 8'hA5, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    repeat (TIMEOUT - 1) step(1'b0, 8'h00, 1'b1);
    chk("to_busy_before", busy, 1);
    chk("to_err_before", err_cnt, exp_err);
    step(1'b0, 8'h00, 1'b1);
    exp_err++;
    chk("to_busy_after", busy, 0);
    chk("to_err_after", err_cnt, exp_err);

    // A byte on the expiry cycle is processed instead.
    step(1'b1, 8'hA5, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    repeat (TIMEOUT - 1) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h05, 1'b1);
    chk("to_win_busy", busy, 1);
    chk("to_win_err", err_cnt, exp_err);
    step(1'b1, 8'h02, 1'b1);
    step(1'b1, 8'h07, 1'b1);
    if (CsumEn) step(1'b1, 8'h03, 1'b1);
    exp_pkt++;
    chk("to_win_valid", wr_valid, 1);
    chk("to_win_y", y_out, 5);
    chk("to_win_pkt", pkt_cnt, exp_pkt);
    step(1'b0, 8'h00, 1'b1);

    // Junk byte in HUNT is ignored; x=64 rejected on range.
    step(1'b1, 8'h11, 1'b1);
    chk("junk_busy", busy, 0);
    chk("junk_err", err_cnt, exp_err);
    send_pkt(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    exp_err++;
    chk("range_err", err_cnt, exp_err);
    chk("range_valid", wr_valid, 0);

    // Reset in GET_Z with a write pending.
    send_pkt(8'd1, 8'd2, 8'd3, 8'd4, 8'h00, 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'd5, 1'b0);
    step(1'b1, 8'd6, 1'b0);
    chk("mid_busy", busy, 1);
    chk("mid_pending", wr_valid, 1);
    apply_reset();
    send_pkt(8'd9, 8'd8, 8'd7, 8'd6, 8'h00, 1'b1);
    chk("post_rst_valid", wr_valid, 1);
    chk("post_rst_x", x_out, 9);
    chk("post_rst_block", block_out, 6);
    chk("post_rst_pkt", pkt_cnt, 1);
    chk("post_rst_err", err_cnt, 0);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int gap;
      logic [7:0] cx;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 9) == 0) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
        else step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end
      cx = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_pkt(8'($urandom_range(0, 70)), 8'($urandom_range(0, 70)),
               8'($urandom_range(0, 20)), 8'($urandom_range(0, 40)), cx,
               1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
